// File: rtl/d_flipflop_pkg.sv
// Shared constants for the d_flipflop register and its companion interface.
//
// DFF_DEFAULT_WIDTH   : default data width of d/q in bits
// DFF_DEFAULT_RST_VAL : default reset value; it is zero-extended or truncated
//                       to WIDTH where it is used
package d_flipflop_pkg;

    localparam int          DFF_DEFAULT_WIDTH   = 1;
    localparam int unsigned DFF_DEFAULT_RST_VAL = 0;

endpackage : d_flipflop_pkg

// File: rtl/inter.sv
// Signal bundle for a d_flipflop instance, shared by test environments.
//
// Ports:
//   clk : input clock, supplied by the environment
// Members:
//   rst : active-low asynchronous reset
//   d   : data into the register (WIDTH bits)
//   q   : registered data out of the register (WIDTH bits)
interface inter
    import d_flipflop_pkg::*;
#(
    parameter int WIDTH = DFF_DEFAULT_WIDTH
) (
    input logic clk
);

    logic             rst;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

endinterface : inter

// File: rtl/d_flipflop.sv
// Parameterised D register with an asynchronous active-low reset.
//
// Parameters:
//   WIDTH   : data width of d and q in bits
//   RST_VAL : value forced onto q while rst is low
// Ports:
//   clk : clock; every rising edge loads d, because there is no enable
//   rst : asynchronous active-low reset (0 = reset, 1 = run)
//   d   : data sampled at each rising edge of clk
//   q   : registered copy of d, driven only by the flop
module d_flipflop
    import d_flipflop_pkg::*;
#(
    parameter int               WIDTH   = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DFF_DEFAULT_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Reset has priority. If rst falls on the same instant as a clock edge,
    // the flop still ends up at RST_VAL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule : d_flipflop

// File: tb/tb_d_flipflop.sv
module tb_d_flipflop;

    localparam logic [7:0] RST8 = 8'hA5;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       q1;
    logic [7:0] q8;

    int checks;
    int failures;

    inter #(.WIDTH(8)) bus8 (.clk(clk));

    assign bus8.rst = rst;
    assign q8       = bus8.q;

    d_flipflop dut1 (
        .clk (clk),
        .rst (rst),
        .d   (d1),
        .q   (q1)
    );

    d_flipflop #(.WIDTH(8), .RST_VAL(RST8)) dut8 (
        .clk (clk),
        .rst (bus8.rst),
        .d   (bus8.d),
        .q   (bus8.q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;   // rising edges at 5, 15, 25, ...

    task automatic at(input int t);
        if (t > int'($time)) #(t - int'($time));
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    initial begin
        logic       exp1;
        logic [7:0] exp8;
        logic       nd1;
        logic [7:0] nd8;
        logic       nrst;

        checks   = 0;
        failures = 0;

        // Reset held for the first 20 ns while d toggles
        rst = 1'b0; d1 = 1'b0; bus8.d = 8'h00;
        at(2);  d1 = 1'b1; bus8.d = 8'hFF;
        at(6);  chk1("rst_hold_a", q1, 1'b0); chk8("rst_hold8_a", q8, RST8);
        at(9);  d1 = 1'b0; bus8.d = 8'h5A;
        at(12); d1 = 1'b1; chk1("rst_hold_b", q1, 1'b0);
        at(16); chk1("rst_hold_c", q1, 1'b0); chk8("rst_hold8_c", q8, RST8);
        at(19); chk1("rst_hold_d", q1, 1'b0);

        // Release between edges: q holds RST_VAL until the edge at 25
        at(20); rst = 1'b1; d1 = 1'b0; bus8.d = 8'h3C;
        at(22); chk1("release_hold", q1, 1'b0); chk8("release_hold8", q8, RST8);
        at(26); chk8("w8_capture", q8, 8'h3C); chk1("cap_zero_init", q1, 1'b0);

        // Basic capture
        at(30); d1 = 1'b1;
        at(36); chk1("capture_one", q1, 1'b1);
        at(40); d1 = 1'b0;
        at(42); chk1("hold_between", q1, 1'b1);
        at(46); chk1("capture_zero", q1, 1'b0);

        // Glitch on d entirely between the edges at 45 and 55
        at(47); d1 = 1'b1;
        at(48); chk1("glitch_mid", q1, 1'b0);
        at(49); d1 = 1'b0;
        at(56); chk1("glitch_after", q1, 1'b0);

        // Async reset at mid-cycle (edge 65 + 3 ns)
        at(60); d1 = 1'b1;
        at(66); chk1("pre_async_q1", q1, 1'b1);
        at(68); rst = 1'b0;
        at(69); chk1("async_assert", q1, 1'b0); chk8("async_assert8", q8, RST8);
        at(73); chk1("async_hold", q1, 1'b0);

        // Release 2 ns before the edge at 85 with d=1
        at(83); rst = 1'b1;
        at(84); chk1("release_pre_edge", q1, 1'b0);
        at(86); chk1("release_2ns", q1, 1'b1); chk8("release_2ns8", q8, 8'h3C);

        // Reset asserted exactly on the edge at 95
        at(95); rst = 1'b0;
        at(96); chk1("coincident", q1, 1'b0); chk8("coincident8", q8, RST8);
        at(99); d1 = 1'b0; bus8.d = 8'hC3;
        at(101); d1 = 1'b1; bus8.d = 8'h3C;
        at(102); chk1("rst_held_activity", q1, 1'b0);

        // Release just after the edge at 105: q waits for the edge at 115
        at(106); rst = 1'b1;
        at(107); chk1("release_late_a", q1, 1'b0);
        at(114); chk1("release_late_b", q1, 1'b0); chk8("release_late8", q8, RST8);
        at(116); chk1("release_late_c", q1, 1'b1); chk8("release_late8_c", q8, 8'h3C);

        // 200 ns of random d with occasional reset pulses.
        // Expected q after an edge is the d presented before that edge, or
        // RST_VAL whenever reset is low.
        for (int k = 0; k < 20; k++) begin
            at(120 + 10 * k);
            nd1  = 1'($urandom_range(0, 1));
            nd8  = 8'($urandom_range(0, 255));
            nrst = ($urandom_range(0, 7) != 0);
            d1 = nd1; bus8.d = nd8; rst = nrst;
            at(121 + 10 * k);
            if (!nrst) begin
                chk1("rand_async", q1, 1'b0);
                chk8("rand_async8", q8, RST8);
            end
            exp1 = nrst ? nd1 : 1'b0;
            exp8 = nrst ? nd8 : RST8;
            at(126 + 10 * k);
            chk1("rand_q1", q1, exp1);
            chk8("rand_q8", q8, exp8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_d_flipflop
